// File: rtl/registrador_universal_if.sv
// Command/data bundle of the universal shift register.
// master = command issuer, slave = registrador_universal.
interface registrador_universal_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         func;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   in_data;
    logic               ser_in;
    logic [WIDTH-1:0]   out_data;
    logic               ser_out;
    logic               busy;
    logic               done;
    logic               zero;

    modport master (
        output cmd_valid, func, shamt, in_data, ser_in,
        input  cmd_ready, out_data, ser_out, busy, done, zero
    );

    modport slave (
        input  cmd_valid, func, shamt, in_data, ser_in,
        output cmd_ready, out_data, ser_out, busy, done, zero
    );
endinterface

// File: rtl/registrador_universal.sv
// Universal shift register: load/reset/hold plus shift/rotate/ashr by a programmable amount.
// Latency: HOLD/LOAD/RESET and zero-amount shifts 1 edge; k-bit shift k+1 edges (one bit per edge).
// Backpressure: cmd_ready = ~busy; commands presented while busy are dropped, never queued.
module registrador_universal #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
) (
    input logic                    clock,
    input logic                    reset_n,
    registrador_universal_if.slave bus
);
    typedef enum logic [2:0] {
        OP_HOLD   = 3'b000,
        OP_LOAD   = 3'b001,
        OP_SHIFTR = 3'b010,
        OP_SHIFTL = 3'b011,
        OP_RESET  = 3'b100,
        OP_ROTR   = 3'b101,
        OP_ROTL   = 3'b110,
        OP_ASHR   = 3'b111
    } op_t;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    state_t             state_q, state_nxt;
    op_t                op_q, op_nxt;
    op_t                cmd_op;
    logic [WIDTH-1:0]   data_q, data_nxt, step_dat;
    logic               ser_q, ser_nxt, step_ser;
    logic               done_q, done_nxt;
    logic [SHAMT_W-1:0] cnt_q, cnt_nxt;
    logic               accept;

    assign cmd_op = op_t'(bus.func);
    assign accept = bus.cmd_valid && (state_q == ST_IDLE);

    // One-bit step of the latched operation; ser_in is sampled live at every step.
    always_comb begin
        step_dat = data_q;
        step_ser = ser_q;
        case (op_q)
            OP_SHIFTR: begin
                step_dat = {bus.ser_in, data_q[WIDTH-1:1]};
                step_ser = data_q[0];
            end
            OP_SHIFTL: begin
                step_dat = {data_q[WIDTH-2:0], bus.ser_in};
                step_ser = data_q[WIDTH-1];
            end
            OP_ROTR: begin
                step_dat = {data_q[0], data_q[WIDTH-1:1]};
                step_ser = data_q[0];
            end
            OP_ROTL: begin
                step_dat = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                step_ser = data_q[WIDTH-1];
            end
            OP_ASHR: begin
                step_dat = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                step_ser = data_q[0];
            end
            default: begin
                step_dat = data_q;
                step_ser = ser_q;
            end
        endcase
    end

    always_comb begin
        state_nxt = state_q;
        op_nxt    = op_q;
        data_nxt  = data_q;
        ser_nxt   = ser_q;
        cnt_nxt   = cnt_q;
        done_nxt  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_HOLD:  done_nxt = 1'b1;
                        OP_LOAD: begin
                            data_nxt = bus.in_data;
                            done_nxt = 1'b1;
                        end
                        OP_RESET: begin
                            data_nxt = '0;
                            done_nxt = 1'b1;
                        end
                        default: begin
                            if (bus.shamt == '0) begin
                                done_nxt = 1'b1;
                            end else begin
                                op_nxt    = cmd_op;
                                cnt_nxt   = bus.shamt;
                                state_nxt = ST_SHIFT;
                            end
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                data_nxt = step_dat;
                ser_nxt  = step_ser;
                cnt_nxt  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            data_q  <= '0;
            ser_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            op_q    <= op_nxt;
            data_q  <= data_nxt;
            ser_q   <= ser_nxt;
            done_q  <= done_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.ser_out   = ser_q;
    assign bus.busy      = (state_q == ST_SHIFT);
    assign bus.cmd_ready = (state_q != ST_SHIFT);
    assign bus.done      = done_q;
    assign bus.zero      = (data_q == '0);
endmodule

// File: tb/tb_registrador_universal.sv
// Directed bench for registrador_universal, WIDTH=8, SHAMT_W=4.
module tb_registrador_universal;
    localparam logic [2:0] F_HOLD = 3'b000, F_LOAD = 3'b001, F_SHR = 3'b010, F_SHL = 3'b011;
    localparam logic [2:0] F_RST  = 3'b100, F_ROR  = 3'b101, F_ROL = 3'b110, F_ASR = 3'b111;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] exp_rol  [3] = '{8'h03, 8'h06, 8'h0C};
    logic [7:0] exp_sr   [2] = '{8'hC8, 8'hE4};
    logic [7:0] exp_shr5 [5] = '{8'h5A, 8'h2D, 8'h16, 8'h0B, 8'h05};
    logic       ser_shr5 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       ser_rol  [3] = '{1'b1, 1'b0, 1'b0};

    registrador_universal_if #(.WIDTH(8), .SHAMT_W(4)) bus ();

    registrador_universal #(.WIDTH(8), .SHAMT_W(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one command for exactly one edge; returns 1 time unit after that edge.
    task automatic send(input logic [2:0] f, input logic [3:0] k, input logic [7:0] d, input logic s);
        bus.cmd_valid = 1'b1;
        bus.func      = f;
        bus.shamt     = k;
        bus.in_data   = d;
        bus.ser_in    = s;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.func      = F_HOLD;
        bus.shamt     = '0;
        bus.in_data   = '0;
        bus.ser_in    = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_out",   bus.out_data, 8'h00);
        chk("rst_busy",  8'(bus.busy), 8'h00);
        chk("rst_done",  8'(bus.done), 8'h00);
        chk("rst_ser",   8'(bus.ser_out), 8'h00);
        chk("rst_zero",  8'(bus.zero), 8'h01);
        chk("rst_ready", 8'(bus.cmd_ready), 8'h01);
        reset_n = 1'b1;

        send(F_LOAD, 4'd0, 8'hA5, 1'b0);
        chk("load_out",  bus.out_data, 8'hA5);
        chk("load_done", 8'(bus.done), 8'h01);
        chk("load_zero", 8'(bus.zero), 8'h00);
        tick();
        chk("load_done_pulse", 8'(bus.done), 8'h00);
        send(F_RST, 4'd0, 8'hFF, 1'b0);
        chk("reset_out",  bus.out_data, 8'h00);
        chk("reset_zero", 8'(bus.zero), 8'h01);
        chk("reset_done", 8'(bus.done), 8'h01);

        send(F_LOAD, 4'd0, 8'h81, 1'b0);
        send(F_ROL, 4'd3, 8'h00, 1'b0);
        chk("rol_t0_out",   bus.out_data, 8'h81);
        chk("rol_t0_busy",  8'(bus.busy), 8'h01);
        chk("rol_t0_ready", 8'(bus.cmd_ready), 8'h00);
        chk("rol_t0_done",  8'(bus.done), 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rol_out",  bus.out_data, exp_rol[i]);
            chk("rol_ser",  8'(bus.ser_out), 8'(ser_rol[i]));
            chk("rol_busy", 8'(bus.busy), (i < 2) ? 8'h01 : 8'h00);
            chk("rol_done", 8'(bus.done), (i == 2) ? 8'h01 : 8'h00);
        end
        tick();
        chk("rol_done_pulse", 8'(bus.done), 8'h00);

        send(F_LOAD, 4'd0, 8'h90, 1'b0);
        send(F_ASR, 4'd2, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("ashr_out", bus.out_data, exp_sr[i]);
            chk("ashr_ser", 8'(bus.ser_out), 8'h00);
        end
        send(F_LOAD, 4'd0, 8'h90, 1'b0);
        send(F_SHR, 4'd2, 8'h00, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("shr_fill_out", bus.out_data, exp_sr[i]);
        end
        chk("shr_fill_done", 8'(bus.done), 8'h01);

        send(F_LOAD, 4'd0, 8'hFF, 1'b0);
        send(F_SHL, 4'd15, 8'h00, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("shl15_out",  bus.out_data, (i >= 8) ? 8'h00 : 8'(8'hFF << i));
            chk("shl15_ser",  8'(bus.ser_out), (i <= 8) ? 8'h01 : 8'h00);
            chk("shl15_busy", 8'(bus.busy), (i < 15) ? 8'h01 : 8'h00);
            chk("shl15_done", 8'(bus.done), (i == 15) ? 8'h01 : 8'h00);
        end

        send(F_LOAD, 4'd0, 8'hB4, 1'b0);
        send(F_SHR, 4'd5, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.cmd_valid = 1'b1;
                bus.func      = F_LOAD;
                bus.in_data   = 8'h00;
            end
            tick();
            bus.cmd_valid = 1'b0;
            chk("busy_ign_out", bus.out_data, exp_shr5[i]);
            chk("busy_ign_ser", 8'(bus.ser_out), 8'(ser_shr5[i]));
        end
        chk("busy_ign_done", 8'(bus.done), 8'h01);
        chk("busy_ign_busy", 8'(bus.busy), 8'h00);

        send(F_ROR, 4'd0, 8'h00, 1'b0);
        chk("ror0_out",  bus.out_data, 8'h05);
        chk("ror0_ser",  8'(bus.ser_out), 8'h01);
        chk("ror0_done", 8'(bus.done), 8'h01);
        chk("ror0_busy", 8'(bus.busy), 8'h00);

        send(F_LOAD, 4'd0, 8'h11, 1'b0);
        chk("b2b_first_done", 8'(bus.done), 8'h01);
        send(F_LOAD, 4'd0, 8'h22, 1'b0);
        chk("b2b_out",  bus.out_data, 8'h22);
        chk("b2b_done", 8'(bus.done), 8'h01);
        chk("b2b_ser",  8'(bus.ser_out), 8'h01);

        send(F_LOAD, 4'd0, 8'hC3, 1'b0);
        send(F_SHL, 4'd6, 8'h00, 1'b1);
        tick();
        chk("abort_s1", bus.out_data, 8'h87);
        tick();
        chk("abort_s2", bus.out_data, 8'h0F);
        chk("abort_s2_ser", 8'(bus.ser_out), 8'h01);
        reset_n = 1'b0;
        #1;
        chk("abort_out",   bus.out_data, 8'h00);
        chk("abort_busy",  8'(bus.busy), 8'h00);
        chk("abort_done",  8'(bus.done), 8'h00);
        chk("abort_ser",   8'(bus.ser_out), 8'h00);
        chk("abort_ready", 8'(bus.cmd_ready), 8'h01);
        tick();
        reset_n = 1'b1;
        send(F_LOAD, 4'd0, 8'h3C, 1'b0);
        chk("post_rst_out",  bus.out_data, 8'h3C);
        chk("post_rst_done", 8'(bus.done), 8'h01);
        tick();
        chk("post_rst_hold", bus.out_data, 8'h3C);
        chk("post_rst_busy", 8'(bus.busy), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
